aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Sequencer for the AES round datapath and its key-expansion unit. It accepts an encrypt request over a valid/ready handshake and latches the key length. It then pulses the datapath restart, steps the key schedule and round counter for Nr+1 round cycles, flags the final round, freezes the datapath, and presents completion over a second valid/ready handshake. Sits between the bus/host wrapper and the cipher + key-expansion pair.

Parameters:
RW, 4, round counter width (must hold 14)
ABORT_EN, 1, 1 = abort input honoured, 0 = abort ignored

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start_valid  in  1  request to encrypt the block/key currently presented to the datapath
start_ready  out  1  controller can accept a request
key_len  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=reserved; sampled on start handshake
abort  in  1  cancel the operation in progress
res_valid  out  1  ciphertext on datapath output is final
res_ready  in  1  consumer takes result
core_rst  out  1  sync active-high restart to datapath and key expansion
core_last  out  1  current round cycle is the final round (no mixcolumns)
core_hold  out  1  freeze datapath state register
key_step  out  1  advance key schedule to next round key
round  out  RW  current round index 0..Nr
busy  out  1  state != IDLE
err  out  1  one-cycle pulse: reserved key_len rejected

Behaviour:
- Reset (reset=0, async): state=IDLE, round=0, nr_q=10; outputs start_ready, res_valid, core_rst, core_last, key_step, busy, err all 0; core_hold=1. After reset release: start_ready=1 in IDLE.
- Nr: 10/12/14 for key_len 00/01/10; latched into nr_q on accept; key_len changes later are ignored.
- States: IDLE, LOAD, ROUND, DONE.
- IDLE: start_ready=1 (0 if abort=1 and ABORT_EN), core_hold=1.
  - Handshake with key_len!=11 → LOAD.
  - key_len==11 → err=1 next cycle; stay IDLE; start_ready stays 1.
- LOAD (1 cycle): core_rst=1, round=0, core_hold=0, key_step=0 → ROUND.
- ROUND: core_hold=0; round increments each cycle from 0 to nr_q.
  - key_step=1 while round<nr_q.
  - core_last=1 only when round==nr_q; then → DONE and round holds nr_q.
- DONE: core_hold=1, res_valid=1, held until res_ready; on res_ready → IDLE, round→0.
  - start_ready=0 in DONE: a start coincident with res_ready is not accepted. One-cycle bubble; earliest next accept is the following cycle.
- Latency: accept at cycle T → core_rst at T+1 → rounds T+2..T+2+Nr → res_valid first high at T+3+Nr. Examples: 13 cycles (128), 15 cycles (192), 17 cycles (256).
- abort (ABORT_EN=1):
  - In LOAD/ROUND/DONE: next state IDLE, round=0, res_valid drops next cycle, no err.
  - Wins over a simultaneous res_ready; result counts as discarded.
  - In IDLE: blocks acceptance that cycle.
- round never exceeds nr_q; no wrap. Counter saturates if state corrupted. Illegal state encoding → IDLE.
- Async reset mid-operation: immediate IDLE with reset values; datapath contents undefined until next LOAD.

Decomposition:
- aes_pkg:
  - keylen_t enum (KL128, KL192, KL256, KLRSV)
  - NR_128/NR_192/NR_256 constants
  - function nr_of(keylen_t)
  - ctrl state enum
- Sub-module aes_round_counter (clear, enable, limit input, at_limit output) instantiated once. FSM and handshake logic stay in aes_round_ctrl.

Test Plan:
- Reset then AES-128 start at T, res_ready=1 → core_rst@T+1; key_step high 10 cycles; core_last@T+12 with round=10; res_valid@T+13; IDLE@T+14.
- AES-256 start, res_ready=0 for 5 cycles → round reaches 14; res_valid held 6 cycles with core_hold=1; accept on 6th; start_ready=1 next cycle.
- key_len=11 start → err pulse 1 cycle, no core_rst, busy stays 0; immediate AES-192 start next cycle → res_valid 15 cycles later.
- Abort at round=5 of AES-128 → IDLE next cycle, no res_valid, round=0; new start accepted the cycle after.
- res_ready and start_valid together in DONE → start not accepted that cycle; accepted next cycle; res_valid of second op at +13.
- Assert reset=0 mid-ROUND (round=7), release → all outputs at reset values immediately; start_ready=1 first cycle after release.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer.
package aes_pkg;

   // Key length code as presented on the request interface.
   typedef enum logic [1:0] {
      KL128 = 2'b00,
      KL192 = 2'b01,
      KL256 = 2'b10,
      KLRSV = 2'b11
   } keylen_t;

   // Number of rounds per key length.
   localparam int unsigned NR_128 = 10;
   localparam int unsigned NR_192 = 12;
   localparam int unsigned NR_256 = 14;

   // Controller state.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_ROUND = 2'b10,
      ST_DONE  = 2'b11
   } ctrl_state_e;

   // Round count for a key length; the reserved code maps to AES-128 and is
   // rejected before it can be latched.
   function automatic int unsigned nr_of(input keylen_t kl);
      int unsigned nr;
      case (kl)
         KL192:   nr = NR_192;
         KL256:   nr = NR_256;
         default: nr = NR_128;
      endcase
      return nr;
   endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Round index counter: cleared on restart, counts up to a limit and sticks.
module aes_round_counter #(
   parameter int unsigned RW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear_i,
   input  logic          enable_i,
   input  logic [RW-1:0] limit_i,
   output logic [RW-1:0] count_o,
   output logic          at_limit_o
);

   logic [RW-1:0] count_q;
   logic [RW-1:0] count_d;

   // Next count: clear wins, otherwise advance only while below the limit.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q < limit_i)) begin
         count_d = count_q + RW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // ">=" so a corrupted count above the limit still reads as finished.
   assign at_limit_o = (count_q >= limit_i);
   assign count_o    = count_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: accepts a request, restarts the datapath, steps the
// key schedule through Nr+1 round cycles and hands back the result.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. start_ready does not depend on start_valid;
// res_valid stays high, with the datapath frozen, until res_ready is seen.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned RW       = 4,
   parameter bit          ABORT_EN = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_valid,
   output logic          start_ready,
   input  logic [1:0]    key_len,
   input  logic          abort,
   output logic          res_valid,
   input  logic          res_ready,
   output logic          core_rst,
   output logic          core_last,
   output logic          core_hold,
   output logic          key_step,
   output logic [RW-1:0] round,
   output logic          busy,
   output logic          err,
   output ctrl_state_e   state_dbg
);

   ctrl_state_e   state_q, state_d;
   logic [RW-1:0] nr_q, nr_d;
   logic          err_q, err_d;
   logic          abort_act;
   logic          accept;
   logic          reject;
   logic          cnt_clear;
   logic          cnt_enable;
   logic          at_limit;

   assign abort_act = ABORT_EN & abort;
   // A request seen in IDLE is either accepted or rejected for a bad key length.
   assign accept = (state_q == ST_IDLE) & start_valid & ~abort_act & (key_len != KLRSV);
   assign reject = (state_q == ST_IDLE) & start_valid & ~abort_act & (key_len == KLRSV);

   // State, latched round count and error pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         nr_q    <= RW'(NR_128);
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         nr_q    <= nr_d;
         err_q   <= err_d;
      end
   end

   // Next state; abort beats everything, including a simultaneous res_ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_LOAD;
         ST_LOAD:  state_d = abort_act ? ST_IDLE : ST_ROUND;
         ST_ROUND: begin
            if (abort_act) begin
               state_d = ST_IDLE;
            end else if (at_limit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE:  if (abort_act || res_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Round count is captured only at acceptance; later key_len changes are ignored.
   always_comb begin
      nr_d = nr_q;
      if (accept) begin
         nr_d = RW'(nr_of(keylen_t'(key_len)));
      end
   end

   assign err_d = reject;

   // Counter restarts whenever we head to IDLE or LOAD, counts during ROUND.
   assign cnt_clear  = (state_d == ST_IDLE) || (state_d == ST_LOAD);
   assign cnt_enable = (state_q == ST_ROUND);

   aes_round_counter #(
      .RW (RW)
   ) u_round_counter (
      .clk        (clk),
      .rst_n      (reset),
      .clear_i    (cnt_clear),
      .enable_i   (cnt_enable),
      .limit_i    (nr_q),
      .count_o    (round),
      .at_limit_o (at_limit)
   );

   // Moore outputs decoded from the current state and round position.
   always_comb begin
      start_ready = 1'b0;
      res_valid   = 1'b0;
      core_rst    = 1'b0;
      core_last   = 1'b0;
      core_hold   = 1'b1;
      key_step    = 1'b0;
      busy        = 1'b1;
      case (state_q)
         ST_IDLE: begin
            start_ready = reset & ~abort_act;
            busy        = 1'b0;
         end
         ST_LOAD: begin
            core_rst  = 1'b1;
            core_hold = 1'b0;
         end
         ST_ROUND: begin
            core_hold = 1'b0;
            key_step  = ~at_limit;
            core_last = at_limit;
         end
         ST_DONE: begin
            res_valid = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign err       = err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a cycle-offset reference model.
module tb_aes_round_ctrl;
   import aes_pkg::*;

   localparam int RW = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic          start_valid = 1'b0;
   logic [1:0]    key_len = 2'b00;
   logic          abort = 1'b0;
   logic          res_ready = 1'b0;
   logic          start_ready, res_valid, core_rst, core_last, core_hold;
   logic          key_step, busy, err;
   logic [RW-1:0] round;
   ctrl_state_e   state_dbg;

   aes_round_ctrl #(.RW(RW), .ABORT_EN(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .key_len     (key_len),
      .abort       (abort),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .core_rst    (core_rst),
      .core_last   (core_last),
      .core_hold   (core_hold),
      .key_step    (key_step),
      .round       (round),
      .busy        (busy),
      .err         (err),
      .state_dbg   (state_dbg)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // An operation is tracked by its offset k from the accept cycle:
   // k=1 restart, k=2..Nr+2 round k-2, k>=Nr+3 result waiting.
   bit m_active = 1'b0;
   int m_k = 0;
   int m_nr = 10;
   bit m_err = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_active <= 1'b0;
         m_k      <= 0;
         m_err    <= 1'b0;
      end else if (!m_active) begin
         m_err <= start_valid && !abort && (key_len == 2'b11);
         if (start_valid && !abort && (key_len != 2'b11)) begin
            m_active <= 1'b1;
            m_k      <= 1;
            m_nr     <= 10 + 2 * int'(key_len);
         end
      end else begin
         m_err <= 1'b0;
         if (abort) m_active <= 1'b0;
         else if ((m_k >= m_nr + 3) && res_ready) m_active <= 1'b0;
         else m_k <= m_k + 1;
      end
   end

   // Compare every output against the model on every falling edge.
   always @(negedge clk) begin
      logic e_sr, e_rv, e_rst, e_last, e_hold, e_ks, e_busy;
      int   e_round;
      e_sr = 0; e_rv = 0; e_rst = 0; e_last = 0; e_hold = 1; e_ks = 0; e_busy = 0;
      e_round = 0;
      if (reset) begin
         if (!m_active) begin
            e_sr = !abort;
         end else begin
            e_busy = 1;
            if (m_k == 1) begin
               e_rst = 1; e_hold = 0;
            end else if (m_k <= m_nr + 2) begin
               e_round = m_k - 2; e_hold = 0;
               e_ks = (e_round < m_nr);
               e_last = (e_round == m_nr);
            end else begin
               e_rv = 1; e_round = m_nr;
            end
         end
      end
      chk("m_start_ready", start_ready, e_sr);
      chk("m_res_valid", res_valid, e_rv);
      chk("m_core_rst", core_rst, e_rst);
      chk("m_core_last", core_last, e_last);
      chk("m_core_hold", core_hold, e_hold);
      chk("m_key_step", key_step, e_ks);
      chk("m_busy", busy, e_busy);
      chk("m_round", round, e_round);
      chk("m_err", err, m_err);
   end

   // ---------------- driver tasks ----------------
   task automatic next_cyc();
      @(posedge clk); #1;
   endtask

   // Issue one request from IDLE and follow it to completion, pinning the
   // latencies with hand-computed values. Entered just after a rising edge.
   task automatic run_op(input logic [1:0] kl, input int rr_wait, input int nr,
                         input int lat, input logic exp_err0);
      int  t0, n_ks, t_rst, t_last, t_rv, rv_cycles;
      bit  done;
      t0 = cyc; n_ks = 0; t_rst = -1; t_last = -1; t_rv = -1; rv_cycles = 0; done = 0;
      start_valid = 1'b1; key_len = kl; res_ready = (rr_wait == 0);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i == 0) begin
            chk("op_err_at_start", err, exp_err0);
            chk("op_ready_at_start", start_ready, 1);
            chk("op_busy_at_start", busy, 0);
         end
         if (key_step) n_ks++;
         if (core_rst && t_rst < 0) t_rst = cyc - t0;
         if (core_last && t_last < 0) begin
            t_last = cyc - t0;
            chk("op_last_round", round, nr);
         end
         if (res_valid) begin
            if (t_rv < 0) t_rv = cyc - t0;
            rv_cycles++;
            chk("op_done_hold", core_hold, 1);
            chk("op_done_round", round, nr);
            if (res_ready) done = 1;
         end
         @(posedge clk); #1;
         start_valid = 1'b0;
         key_len = 2'b11;
         if (done) break;
         res_ready = (rv_cycles >= rr_wait);
      end
      res_ready = 1'b0;
      chk("op_handshake", done, 1);
      chk("op_core_rst_ofs", t_rst, 1);
      chk("op_core_last_ofs", t_last, lat - 1);
      chk("op_res_valid_ofs", t_rv, lat);
      chk("op_key_steps", n_ks, nr);
      chk("op_res_valid_len", rv_cycles, rr_wait + 1);
      @(negedge clk);
      chk("op_idle_ready", start_ready, 1);
      chk("op_idle_busy", busy, 0);
      chk("op_idle_round", round, 0);
   endtask

   task automatic wait_round(input int r);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (round == RW'(r)) break;
      end
      chk("wait_round", round, r);
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // ---------------- directed sequence ----------------
   initial begin
      // Reset values while reset is held low.
      @(negedge clk);
      chk("rst_start_ready", start_ready, 0);
      chk("rst_core_hold", core_hold, 1);
      chk("rst_round", round, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_err", err, 0);
      next_cyc();
      next_cyc();
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", start_ready, 1);

      // AES-128 with consumer always ready: 13-cycle latency.
      next_cyc();
      run_op(2'b00, 0, 10, 13, 1'b0);

      // AES-256 with consumer stalling 5 cycles.
      next_cyc();
      run_op(2'b10, 5, 14, 17, 1'b0);

      // Reserved key length, then AES-192 on the very next cycle.
      next_cyc();
      start_valid = 1'b1; key_len = 2'b11;
      @(negedge clk);
      chk("rsv_ready", start_ready, 1);
      chk("rsv_err_not_yet", err, 0);
      next_cyc();
      run_op(2'b01, 0, 12, 15, 1'b1);

      // Abort during round 5 of AES-128, restart immediately afterwards.
      next_cyc();
      start_valid = 1'b1; key_len = 2'b00;
      next_cyc();
      start_valid = 1'b0;
      wait_round(4);
      next_cyc();
      abort = 1'b1;
      @(negedge clk);
      chk("abort_round5", round, 5);
      next_cyc();
      abort = 1'b0;
      run_op(2'b00, 0, 10, 13, 1'b0);

      // Abort in IDLE blocks a simultaneous request.
      next_cyc();
      abort = 1'b1; start_valid = 1'b1; key_len = 2'b00;
      @(negedge clk);
      chk("abort_idle_ready", start_ready, 0);
      next_cyc();
      abort = 1'b0;
      run_op(2'b01, 0, 12, 15, 1'b0);

      // res_ready and start_valid together in DONE: start taken one cycle later.
      next_cyc();
      start_valid = 1'b1; key_len = 2'b00; res_ready = 1'b0;
      next_cyc();
      start_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (res_valid) break;
      end
      chk("done_reached", res_valid, 1);
      next_cyc();
      res_ready = 1'b1; start_valid = 1'b1; key_len = 2'b00;
      @(negedge clk);
      chk("done_no_accept", start_ready, 0);
      chk("done_valid", res_valid, 1);
      next_cyc();
      run_op(2'b00, 0, 10, 13, 1'b0);

      // Asynchronous reset in round 7 of AES-256.
      next_cyc();
      start_valid = 1'b1; key_len = 2'b10;
      next_cyc();
      start_valid = 1'b0;
      wait_round(6);
      next_cyc();
      @(negedge clk);
      chk("pre_rst_round", round, 7);
      #1 reset = 1'b0;
      #1;
      chk("arst_round", round, 0);
      chk("arst_busy", busy, 0);
      chk("arst_hold", core_hold, 1);
      chk("arst_key_step", key_step, 0);
      chk("arst_last", core_last, 0);
      chk("arst_start_ready", start_ready, 0);
      chk("arst_res_valid", res_valid, 0);
      next_cyc();
      reset = 1'b1;
      @(negedge clk);
      chk("arst_release_ready", start_ready, 1);
      next_cyc();
      run_op(2'b00, 0, 10, 13, 1'b0);

      next_cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
